// File: rtl/bp_tlb_event_recorder_if.sv
// rtl/bp_tlb_event_recorder_if.sv - TLB event record stream between the recorder and its consumer
interface bp_tlb_event_recorder_if #(
    parameter int vtag_width_p = 27,
    parameter int ptag_width_p = 28
);
    logic                    event_v;
    logic                    event_tlb;
    logic [1:0]              event_type;
    logic [vtag_width_p-1:0] event_vtag;
    logic [ptag_width_p-1:0] event_ptag;
    logic [2:0]              event_perm;
    logic                    event_yumi;

    modport master (
        output event_v, event_tlb, event_type, event_vtag, event_ptag, event_perm,
        input  event_yumi
    );

    modport slave (
        input  event_v, event_tlb, event_type, event_vtag, event_ptag, event_perm,
        output event_yumi
    );
endinterface

// File: rtl/bp_tlb_event_recorder.sv
// rtl/bp_tlb_event_recorder.sv - packs ITLB/DTLB clear/fill strobes into a FIFO of event records with read/drop accounting
module bp_tlb_event_recorder #(
    parameter int vtag_width_p = 27,
    parameter int ptag_width_p = 28,
    parameter int fifo_els_p   = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    freeze_i,

    input  logic                    itlb_clear_i,
    input  logic                    itlb_fill_v_i,
    input  logic [vtag_width_p-1:0] itlb_vtag_i,
    input  logic [ptag_width_p-1:0] itlb_ptag_i,
    input  logic [2:0]              itlb_perm_i,
    input  logic                    itlb_cam_r_v_i,

    input  logic                    dtlb_clear_i,
    input  logic                    dtlb_fill_v_i,
    input  logic [vtag_width_p-1:0] dtlb_vtag_i,
    input  logic [ptag_width_p-1:0] dtlb_ptag_i,
    input  logic [2:0]              dtlb_perm_i,
    input  logic                    dtlb_cam_r_v_i,

    bp_tlb_event_recorder_if.master evt,

    output logic [31:0]             itlb_reads_o,
    output logic [31:0]             dtlb_reads_o,
    output logic [15:0]             dropped_o,
    output logic                    overflow_o
);
    localparam int lg_lp    = $clog2(fifo_els_p);
    localparam int rec_w_lp = 1 + 2 + vtag_width_p + ptag_width_p + 3;
    localparam logic [lg_lp:0] depth_lp = (lg_lp+1)'(fifo_els_p);

    logic [rec_w_lp-1:0] mem [fifo_els_p];
    logic [lg_lp-1:0]    rd_ptr_r, wr_ptr_r;
    logic [lg_lp:0]      count_r;
    logic [31:0]         itlb_reads_r, dtlb_reads_r;
    logic [15:0]         dropped_r;
    logic                overflow_r;

    logic                i_v, d_v, deq;
    logic [rec_w_lp-1:0] i_rec, d_rec, first_rec, head_rec;
    logic [lg_lp:0]      free_slots;
    logic [1:0]          req_cnt, enq_cnt, drop_cnt;
    logic [16:0]         drop_sum;
    logic [15:0]         dropped_next;

    // Clear-only records carry zeroed fill fields; type is simply {fill, clear}.
    always_comb begin
        i_rec = {1'b0, itlb_fill_v_i, itlb_clear_i,
                 itlb_fill_v_i ? itlb_vtag_i : '0,
                 itlb_fill_v_i ? itlb_ptag_i : '0,
                 itlb_fill_v_i ? itlb_perm_i : 3'b000};
        d_rec = {1'b1, dtlb_fill_v_i, dtlb_clear_i,
                 dtlb_fill_v_i ? dtlb_vtag_i : '0,
                 dtlb_fill_v_i ? dtlb_ptag_i : '0,
                 dtlb_fill_v_i ? dtlb_perm_i : 3'b000};
    end

    // Slot availability is judged before this cycle's dequeue, so a full FIFO drops even when yumi is high.
    always_comb begin
        i_v        = !freeze_i && (itlb_clear_i || itlb_fill_v_i);
        d_v        = !freeze_i && (dtlb_clear_i || dtlb_fill_v_i);
        first_rec  = i_v ? i_rec : d_rec;
        req_cnt    = {1'b0, i_v} + {1'b0, d_v};
        free_slots = depth_lp - count_r;
        enq_cnt    = (free_slots >= (lg_lp+1)'(req_cnt)) ? req_cnt : free_slots[1:0];
        drop_cnt   = req_cnt - enq_cnt;
        deq        = evt.event_yumi && (count_r != '0);
        drop_sum   = {1'b0, dropped_r} + 17'(drop_cnt);
        dropped_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (enq_cnt != 2'd0) mem[wr_ptr_r] <= first_rec;
        if (enq_cnt == 2'd2) mem[wr_ptr_r + lg_lp'(1)] <= d_rec;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            itlb_reads_r <= '0;
            dtlb_reads_r <= '0;
            dropped_r    <= '0;
            overflow_r   <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_r + lg_lp'(enq_cnt);
            rd_ptr_r  <= rd_ptr_r + lg_lp'(deq);
            count_r   <= count_r + (lg_lp+1)'(enq_cnt) - (lg_lp+1)'(deq);
            dropped_r <= dropped_next;
            if (drop_cnt != 2'd0) overflow_r <= 1'b1;
            if (!freeze_i && itlb_cam_r_v_i && (itlb_reads_r != 32'hFFFF_FFFF))
                itlb_reads_r <= itlb_reads_r + 32'd1;
            if (!freeze_i && dtlb_cam_r_v_i && (dtlb_reads_r != 32'hFFFF_FFFF))
                dtlb_reads_r <= dtlb_reads_r + 32'd1;
        end
    end

    always_comb begin
        head_rec = (count_r != '0) ? mem[rd_ptr_r] : '0;
    end

    assign evt.event_v = (count_r != '0);
    assign {evt.event_tlb, evt.event_type, evt.event_vtag, evt.event_ptag, evt.event_perm} = head_rec;

    assign itlb_reads_o = itlb_reads_r;
    assign dtlb_reads_o = dtlb_reads_r;
    assign dropped_o    = dropped_r;
    assign overflow_o   = overflow_r;
endmodule
